tick_sequencer: RTL and testbench
=================================

Name: tick_sequencer

Overview:
- Programmable timebase controller built around an internal divider.
- The divider has the same contract as the team's converter block: it counts 0..max and emits a 1-cycle pulse on the cycle after `count==max`, for a period of max+1 cycles.
- The block steps the divider through a table of up to 2^ADDR_W segments; each segment has its own period and repeat count.
- Used to drive LED patterns, tone sequences and display scan timing from one clock, without the caller reprogramming a divider by hand.

Parameters:
- CNT_W, 32: divider counter and period width.
- REP_W, 16: repeat-count width.
- ADDR_W, 2: segment index width; the table holds 2^ADDR_W entries.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_we  in  1  table write strobe; honoured only when busy=0.
- cfg_addr  in  ADDR_W  table entry to write.
- cfg_period  in  CNT_W  divider max for the entry; tick period is cfg_period+1 cycles.
- cfg_repeat  in  REP_W  ticks emitted in the entry before advancing; 0 is treated as 1.
- last_seg  in  ADDR_W  index of the final segment; sampled on start.
- loop  in  1  1 = wrap from last_seg to segment 0 indefinitely; sampled on start.
- start  in  1  1-cycle request to begin at segment 0.
- stop  in  1  abort request.
- tick  out  1  1-cycle pulse, one per divider wrap.
- seg_idx  out  ADDR_W  segment currently running.
- busy  out  1  high while in RUN.
- done  out  1  1-cycle pulse when a non-loop sequence completes.

Behaviour:
Reset (rst_n=0, asynchronous):
- State=IDLE.
- tick, done, busy = 0; seg_idx = 0.
- Divider count, repeat count and all table entries = 0.
- Reset asserted mid-RUN aborts immediately. No done pulse is produced.

State machine:
- IDLE:
  - Table writes are accepted: entry[cfg_addr] ← {cfg_period, cfg_repeat} at the edge where cfg_we=1.
  - start=1 and stop=0: latch last_seg and loop, clear count, rep and seg_idx, go to RUN. busy=1 from the next cycle.
  - start and stop in the same cycle: stop wins and the block stays in IDLE.
- RUN:
  - The divider counts +1 per cycle.
  - At an edge where count==period[seg_idx]:
    - count ← 0, and tick=1 for the following cycle (registered).
    - If rep+1 ≥ max(repeat[seg_idx],1): rep ← 0 and the segment advances.
    - Otherwise rep ← rep+1.
  - Advance when seg_idx < last_seg: seg_idx+1.
  - Advance when seg_idx == last_seg:
    - loop=1: seg_idx ← 0.
    - loop=0: go to IDLE; done=1 in the same cycle as the final tick; busy=0 from that cycle.
  - The new segment's period takes effect from count=0. There is no partial period.
- Timing:
  - First tick appears P+1 cycles after the start edge, where P = period[0].
  - Later ticks within a segment are spaced period+1 cycles apart.
  - Across a segment change, the spacing is the new segment's period+1.
- stop=1 in RUN:
  - Go to IDLE at that edge; busy=0 next cycle.
  - A tick due at that edge is suppressed. done stays 0.
  - seg_idx holds its last value until the next start.
- Ignored inputs:
  - start while in RUN is ignored; it does not restart the sequence.
  - cfg_we while busy is ignored; table contents stay unchanged.
- Edge cases:
  - last_seg and loop changes during RUN have no effect.
  - period=0 gives a tick every cycle while in that segment.
  - Counter compare is equality only. Count never exceeds period because period is fixed for the life of a segment.

Test Plan:
1. Reset then idle:
   - Stimulus: rst_n low for 3 cycles, released.
   - Required: tick, done, busy, seg_idx all 0; no tick for 100 cycles.
2. Single segment:
   - Stimulus: entry0={4,3}, last_seg=0, loop=0, pulse start.
   - Required: ticks at cycles 5, 10, 15 after the start edge; done coincides with the third tick; busy falls at that cycle.
3. Two segments:
   - Stimulus: entry0={1,2}, entry1={0,3}, last_seg=1, loop=0.
   - Required: ticks at +2, +4, then +5, +6, +7; seg_idx goes 0→1 after the second tick; one done.
4. Loop and stop:
   - Stimulus: entry0={2,1}, loop=1, last_seg=0, start; assert stop on the cycle a tick is due after the 4th tick.
   - Required: exactly 4 ticks; no done; busy=0 next cycle.
5. Ignored requests while busy:
   - Stimulus: during RUN of test 2, pulse start and write entry0={9,9}.
   - Required: tick timing unchanged. A rerun after done still shows {4,3} timing.
6. Reset mid-run and repeat=0:
   - Stimulus: drop rst_n mid-segment.
   - Required: outputs are 0 asynchronously and the table reads back 0 (entry0={0,0}). A subsequent start yields one tick at +1 then done.

Source files
------------

// File: rtl/tick_sequencer.sv
// Steps an internal 0..max divider through a table of {period, repeat} segments and emits one tick per wrap.
// Ticks are registered and appear the cycle after count==period; there is no backpressure, and the table accepts writes only while idle.
module tick_sequencer #(
    parameter int CNT_W  = 32,
    parameter int REP_W  = 16,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [REP_W-1:0]  cfg_repeat,
    input  logic [ADDR_W-1:0] last_seg,
    input  logic              loop,
    input  logic              start,
    input  logic              stop,
    output logic              tick,
    output logic [ADDR_W-1:0] seg_idx,
    output logic              busy,
    output logic              done
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [REP_W-1:0]    rep_q, rep_d;
    logic [ADDR_W-1:0]   seg_q, seg_d;
    logic [ADDR_W-1:0]   last_q, last_d;
    logic                loop_q, loop_d;
    logic                tick_q, tick_d;
    logic                done_q, done_d;

    logic [CNT_W-1:0]    per_q [DEPTH];
    logic [REP_W-1:0]    rpt_q [DEPTH];
    logic                tbl_we;

    logic [CNT_W-1:0]    cur_per;
    logic [REP_W-1:0]    cur_rpt;
    logic [REP_W:0]      rep_inc;
    logic                wrap;
    logic                seg_end;

    assign cur_per = per_q[seg_q];
    // A repeat of zero behaves as a single tick.
    assign cur_rpt = (rpt_q[seg_q] == '0) ? REP_W'(1) : rpt_q[seg_q];
    assign rep_inc = {1'b0, rep_q} + 1'b1;
    assign wrap    = (cnt_q == cur_per);
    assign seg_end = (rep_inc >= {1'b0, cur_rpt});

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rep_d   = rep_q;
        seg_d   = seg_q;
        last_d  = last_q;
        loop_d  = loop_q;
        tick_d  = 1'b0;
        done_d  = 1'b0;
        tbl_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                tbl_we = cfg_we;
                if (start && !stop) begin
                    state_d = S_RUN;
                    last_d  = last_seg;
                    loop_d  = loop;
                    cnt_d   = '0;
                    rep_d   = '0;
                    seg_d   = '0;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (wrap) begin
                    cnt_d  = '0;
                    tick_d = 1'b1;
                    if (seg_end) begin
                        rep_d = '0;
                        if (seg_q < last_q) begin
                            seg_d = seg_q + 1'b1;
                        end else if (loop_q) begin
                            seg_d = '0;
                        end else begin
                            // seg_idx keeps the final segment until the next start.
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        rep_d = rep_inc[REP_W-1:0];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rep_q   <= '0;
            seg_q   <= '0;
            last_q  <= '0;
            loop_q  <= 1'b0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rep_q   <= rep_d;
            seg_q   <= seg_d;
            last_q  <= last_d;
            loop_q  <= loop_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                per_q[i] <= '0;
                rpt_q[i] <= '0;
            end
        end else if (tbl_we) begin
            per_q[cfg_addr] <= cfg_period;
            rpt_q[cfg_addr] <= cfg_repeat;
        end
    end

    assign tick    = tick_q;
    assign done    = done_q;
    assign seg_idx = seg_q;
    assign busy    = (state_q == S_RUN);

endmodule

// File: tb/tb_tick_sequencer.sv
// Randomized and directed bench for tick_sequencer against an event-schedule reference model.
module tb_tick_sequencer;

    localparam int CNT_W  = 32;
    localparam int REP_W  = 16;
    localparam int ADDR_W = 2;
    localparam int HORIZON = 400;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_we = 1'b0;
    logic [ADDR_W-1:0] cfg_addr = '0;
    logic [CNT_W-1:0]  cfg_period = '0;
    logic [REP_W-1:0]  cfg_repeat = '0;
    logic [ADDR_W-1:0] last_seg = '0;
    logic              loop = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              tick;
    logic [ADDR_W-1:0] seg_idx;
    logic              busy;
    logic              done;

    tick_sequencer #(.CNT_W(CNT_W), .REP_W(REP_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_period (cfg_period),
        .cfg_repeat (cfg_repeat),
        .last_seg   (last_seg),
        .loop       (loop),
        .start      (start),
        .stop       (stop),
        .tick       (tick),
        .seg_idx    (seg_idx),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int edge_n = 0;
    int n_tick = 0;
    int n_done = 0;

    // Reference model: the table plus a precomputed list of tick times.
    int  m_per [4];
    int  m_rep [4];
    int  m_last = 0;
    bit  m_loop = 1'b0;
    bit  m_run = 1'b0;
    int  tq [$];
    int  sq [$];
    bit  exp_tick = 1'b0;
    bit  exp_done = 1'b0;
    int  exp_seg = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_per[i] = 0;
            m_rep[i] = 0;
        end
        m_run = 1'b0;
        tq.delete();
        sq.delete();
        exp_tick = 1'b0;
        exp_done = 1'b0;
        exp_seg = 0;
    endtask

    task automatic build(input int e);
        int t;
        t = e;
        tq.delete();
        sq.delete();
        do begin
            for (int g = 0; g <= m_last; g++) begin
                int r;
                r = (m_rep[g] == 0) ? 1 : m_rep[g];
                for (int k = 0; k < r; k++) begin
                    t += m_per[g] + 1;
                    tq.push_back(t);
                    sq.push_back(g);
                end
            end
        end while (m_loop && t <= e + HORIZON);
    endtask

    task automatic model_edge();
        exp_tick = 1'b0;
        exp_done = 1'b0;
        if (!m_run) begin
            if (cfg_we) begin
                m_per[cfg_addr] = int'(cfg_period);
                m_rep[cfg_addr] = int'(cfg_repeat);
            end
            if (start && !stop) begin
                m_last = int'(last_seg);
                m_loop = loop;
                build(edge_n);
                m_run = 1'b1;
                exp_seg = 0;
            end
        end else if (stop) begin
            m_run = 1'b0;
            tq.delete();
            sq.delete();
        end else if (tq.size() > 0 && tq[0] == edge_n) begin
            exp_tick = 1'b1;
            void'(tq.pop_front());
            void'(sq.pop_front());
            if (tq.size() == 0) begin
                exp_done = 1'b1;
                m_run = 1'b0;
            end else begin
                exp_seg = sq[0];
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        edge_n++;
        if (rst_n) model_edge();
        @(negedge clk);
        check("tick", 32'(tick), 32'(exp_tick));
        check("done", 32'(done), 32'(exp_done));
        check("busy", 32'(busy), 32'(m_run));
        check("seg_idx", 32'(seg_idx), 32'(exp_seg));
        if (tick) n_tick++;
        if (done) n_done++;
    endtask

    task automatic wr(input int a, input int p, input int r);
        cfg_we = 1'b1;
        cfg_addr = ADDR_W'(a);
        cfg_period = CNT_W'(p);
        cfg_repeat = REP_W'(r);
        cyc();
        cfg_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        int stop_at;
        model_reset();

        // Reset then idle
        repeat (3) begin
            @(posedge clk);
            edge_n++;
            @(negedge clk);
            check("rst_tick", 32'(tick), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_seg", 32'(seg_idx), 32'd0);
        end
        rst_n = 1'b1;
        n_tick = 0;
        repeat (100) cyc();
        check("idle_no_tick", 32'(n_tick), 32'd0);

        // Single segment, with ignored start and write while busy
        wr(0, 4, 3);
        last_seg = '0;
        loop = 1'b0;
        n_tick = 0;
        n_done = 0;
        pulse_start();
        repeat (4) cyc();
        start = 1'b1;
        cfg_we = 1'b1;
        cfg_addr = '0;
        cfg_period = CNT_W'(9);
        cfg_repeat = REP_W'(9);
        cyc();
        start = 1'b0;
        cfg_we = 1'b0;
        repeat (14) cyc();
        check("t2_ticks", 32'(n_tick), 32'd3);
        check("t2_done", 32'(n_done), 32'd1);
        n_tick = 0;
        n_done = 0;
        pulse_start();
        repeat (16) cyc();
        check("t5_rerun_ticks", 32'(n_tick), 32'd3);
        check("t5_rerun_done", 32'(n_done), 32'd1);

        // Two segments
        wr(0, 1, 2);
        wr(1, 0, 3);
        last_seg = ADDR_W'(1);
        n_tick = 0;
        n_done = 0;
        pulse_start();
        repeat (9) cyc();
        check("t3_ticks", 32'(n_tick), 32'd5);
        check("t3_done", 32'(n_done), 32'd1);

        // Loop then stop on a due tick
        wr(0, 2, 1);
        last_seg = '0;
        loop = 1'b1;
        n_tick = 0;
        n_done = 0;
        pulse_start();
        repeat (14) cyc();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        check("t4_busy_after_stop", 32'(busy), 32'd0);
        repeat (10) cyc();
        check("t4_ticks", 32'(n_tick), 32'd4);
        check("t4_done", 32'(n_done), 32'd0);
        loop = 1'b0;

        // start together with stop stays idle
        start = 1'b1;
        stop = 1'b1;
        cyc();
        start = 1'b0;
        stop = 1'b0;
        check("ss_busy", 32'(busy), 32'd0);
        repeat (3) cyc();

        // Reset mid-run, then zeroed table gives one immediate tick
        wr(0, 3, 1);
        wr(1, 3, 2);
        last_seg = ADDR_W'(1);
        pulse_start();
        repeat (4) cyc();
        #1 rst_n = 1'b0;
        #1;
        check("arst_tick", 32'(tick), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_seg", 32'(seg_idx), 32'd0);
        model_reset();
        repeat (2) begin
            @(posedge clk);
            edge_n++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        last_seg = '0;
        loop = 1'b0;
        n_tick = 0;
        n_done = 0;
        pulse_start();
        cyc();
        check("t6_tick_at_1", 32'(n_tick), 32'd1);
        check("t6_done_at_1", 32'(n_done), 32'd1);
        repeat (3) cyc();

        // Randomized runs
        for (int run = 0; run < 30; run++) begin
            repeat ($urandom_range(4, 1)) begin
                cfg_we = 1'($urandom_range(1, 0));
                cfg_addr = ADDR_W'($urandom_range(3, 0));
                cfg_period = CNT_W'($urandom_range(5, 0));
                cfg_repeat = REP_W'($urandom_range(3, 0));
                cyc();
            end
            cfg_we = 1'b0;
            last_seg = ADDR_W'($urandom_range(3, 0));
            loop = ($urandom_range(3, 0) == 0);
            start = 1'b1;
            stop = ($urandom_range(7, 0) == 0);
            cyc();
            start = 1'b0;
            stop = 1'b0;
            if (loop) stop_at = int'($urandom_range(150, 5));
            else if ($urandom_range(3, 0) == 0) stop_at = int'($urandom_range(40, 2));
            else stop_at = -1;
            for (int k = 0; k < 300 && m_run; k++) begin
                start = ($urandom_range(7, 0) == 0);
                cfg_we = ($urandom_range(7, 0) == 0);
                cfg_addr = ADDR_W'($urandom_range(3, 0));
                cfg_period = CNT_W'($urandom_range(5, 0));
                cfg_repeat = REP_W'($urandom_range(3, 0));
                last_seg = ADDR_W'($urandom_range(3, 0));
                loop = 1'($urandom_range(1, 0));
                stop = (k == stop_at);
                cyc();
            end
            start = 1'b0;
            cfg_we = 1'b0;
            stop = 1'b0;
            check("rand_run_ended", 32'(busy), 32'd0);
            repeat (2) cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
